// File: rtl/bcd_decoder_pkg.sv
// Shared types and decode helpers for the registered N-of-M line decoder.
// Latency: combinational helpers only; no state.
// Backpressure: n/a.
package bcd_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    SCAN
  } state_t;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  // Widest select the helpers accept. Selects are zero-extended one bit past
  // this so an out-of-range value can never alias onto a legal line index.
  localparam int MAX_SEL_W = 16;
  typedef logic [MAX_SEL_W:0] sel_ext_t;

  // Level of line k for a given select. An out-of-range select matches no
  // line, so every line comes back inactive.
  function automatic logic decode_line(input sel_ext_t sel, input int k,
                                       input logic active_low);
    logic hit;
    hit = (int'(sel) == k);
    return active_low ? ~hit : hit;
  endfunction

  // Error flag that travels with a decoded beat.
  function automatic logic sel_oob(input sel_ext_t sel, input int n_out);
    return int'(sel) >= n_out;
  endfunction

endpackage

// File: rtl/bcd_decoder_scan_skid_buf.sv
// 2-entry valid/ready skid buffer for decoded beats. Outputs come from the head register.
// Latency: a beat pushed into an empty buffer is presented one cycle after acceptance.
// Backpressure: in_rdy is registered and drops only when both entries are full.
//   The buffer refuses new beats while in_en is low and keeps draining what it holds.
module dec_skid_buf #(
  parameter int              W        = 11,
  parameter logic [W-1:0]    IDLE_DAT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_en,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat,
  output logic         empty
);

  logic         h_vld_q, h_vld_n;
  logic         t_vld_q, t_vld_n;
  logic [W-1:0] h_dat_q, h_dat_n;
  logic [W-1:0] t_dat_q, t_dat_n;
  logic         in_rdy_q, in_rdy_n;
  logic         push, pop;

  assign push = in_vld & in_rdy_q;
  assign pop  = h_vld_q & out_rdy;

  // Next head/tail contents. The tail is only ever valid while the head is,
  // so occupancy is h_vld + t_vld. A drained head falls back to IDLE_DAT so
  // the lines read inactive whenever nothing is being presented.
  always_comb begin
    h_vld_n = h_vld_q;
    t_vld_n = t_vld_q;
    h_dat_n = h_dat_q;
    t_dat_n = t_dat_q;
    if (pop) begin
      if (t_vld_q) begin
        h_dat_n = t_dat_q;
        if (push) begin
          t_dat_n = in_dat;
        end else begin
          t_vld_n = 1'b0;
        end
      end else if (push) begin
        h_dat_n = in_dat;
      end else begin
        h_vld_n = 1'b0;
        h_dat_n = IDLE_DAT;
      end
    end else if (push) begin
      if (!h_vld_q) begin
        h_vld_n = 1'b1;
        h_dat_n = in_dat;
      end else begin
        t_vld_n = 1'b1;
        t_dat_n = in_dat;
      end
    end
    in_rdy_n = in_en && !(h_vld_n && t_vld_n);
  end

  // Entry registers and the registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_vld_q  <= 1'b0;
      t_vld_q  <= 1'b0;
      h_dat_q  <= IDLE_DAT;
      t_dat_q  <= IDLE_DAT;
      in_rdy_q <= 1'b0;
    end else begin
      h_vld_q  <= h_vld_n;
      t_vld_q  <= t_vld_n;
      h_dat_q  <= h_dat_n;
      t_dat_q  <= t_dat_n;
      in_rdy_q <= in_rdy_n;
    end
  end

  assign in_rdy  = in_rdy_q;
  assign out_vld = h_vld_q;
  assign out_dat = h_dat_q;
  assign empty   = ~h_vld_q;

endmodule

// File: rtl/bcd_decoder_scan.sv
// Registered select -> one-hot line decoder with a handshaked STREAM path and a self-timed SCAN strobe.
// Latency: STREAM beat out 1 cycle after acceptance into an empty buffer; SCAN holds each line dwell+1 cycles.
// Backpressure: in_ready registered (buffer not full, STREAM only); out_ready low holds the current beat/line.
module bcd_decoder_scan
  import bcd_decoder_pkg::*;
#(
  parameter int SEL_W      = 4,
  parameter int N_OUT      = 10,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int DWELL_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   in_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_OUT-1:0]   out_lines,
  output logic               out_err,
  output logic [7:0]         err_cnt
);

  localparam logic [N_OUT-1:0]   LINES_OFF = {N_OUT{ACTIVE_LOW}};
  localparam logic [SEL_W-1:0]   IDX_ONE   = SEL_W'(1);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  state_t state_q, state_n;

  // Stream path signals
  logic             buf_in_en;
  logic             buf_rdy;
  logic             buf_vld;
  logic             buf_empty;
  logic [N_OUT:0]   buf_dat;
  logic [N_OUT-1:0] in_lines;
  logic             in_oob;
  logic             push;

  // Scan path state
  logic [SEL_W-1:0]   scan_idx_q, scan_idx_n;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_n;
  logic               scan_vld_q, scan_vld_n;
  logic [N_OUT-1:0]   scan_lines_q, scan_lines_n;
  logic               scan_hs;

  logic [7:0] err_cnt_q;

  assign push    = in_valid & buf_rdy;
  assign scan_hs = (state_q == SCAN) && scan_vld_q && out_ready;

  // Mode sequencing. Leaving STREAM goes through DRAIN so buffered beats are
  // delivered first; leaving SCAN waits until no strobe is left pending.
  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:    state_n = mode ? SCAN : STREAM;
      STREAM:  if (mode) state_n = DRAIN;
      DRAIN:   if (buf_empty) state_n = SCAN;
      SCAN:    if (!mode && (!scan_vld_q || out_ready)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Decode the incoming select once, at acceptance; the buffer stores lines.
  always_comb begin
    in_lines = LINES_OFF;
    for (int k = 0; k < N_OUT; k++) begin
      in_lines[k] = decode_line(sel_ext_t'(in_sel), k, ACTIVE_LOW);
    end
    in_oob = sel_oob(sel_ext_t'(in_sel), N_OUT);
  end

  // Ready for the next cycle is only granted if we will still be streaming.
  assign buf_in_en = (state_n == STREAM);

  dec_skid_buf #(
    .W        (N_OUT + 1),
    .IDLE_DAT ({1'b0, LINES_OFF})
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_en   (buf_in_en),
    .in_vld  (in_valid),
    .in_rdy  (buf_rdy),
    .in_dat  ({in_oob, in_lines}),
    .out_vld (buf_vld),
    .out_rdy (out_ready),
    .out_dat (buf_dat),
    .empty   (buf_empty)
  );

  // Scan index/dwell next-state. Entering SCAN restarts at line 0 with a fresh
  // dwell; each accepted strobe advances (wrapping at N_OUT-1) and reloads the
  // dwell from the live input. Lines are decoded from the next index so they
  // change on the same edge as the index.
  always_comb begin
    scan_idx_n   = scan_idx_q;
    dwell_cnt_n  = dwell_cnt_q;
    scan_lines_n = LINES_OFF;
    if (state_n != SCAN) begin
      scan_idx_n  = '0;
      dwell_cnt_n = '0;
    end else if (state_q != SCAN) begin
      scan_idx_n  = '0;
      dwell_cnt_n = dwell;
    end else if (scan_hs) begin
      scan_idx_n  = (int'(scan_idx_q) == N_OUT - 1) ? '0 : scan_idx_q + IDX_ONE;
      dwell_cnt_n = dwell;
    end else if (dwell_cnt_q != '0) begin
      dwell_cnt_n = dwell_cnt_q - DWELL_ONE;
    end
    scan_vld_n = (state_n == SCAN) && (dwell_cnt_n == '0);
    if (state_n == SCAN) begin
      for (int k = 0; k < N_OUT; k++) begin
        scan_lines_n[k] = decode_line(sel_ext_t'(scan_idx_n), k, ACTIVE_LOW);
      end
    end
  end

  // Scan registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_idx_q   <= '0;
      dwell_cnt_q  <= '0;
      scan_vld_q   <= 1'b0;
      scan_lines_q <= LINES_OFF;
    end else begin
      scan_idx_q   <= scan_idx_n;
      dwell_cnt_q  <= dwell_cnt_n;
      scan_vld_q   <= scan_vld_n;
      scan_lines_q <= scan_lines_n;
    end
  end

  // Saturating count of out-of-range beats taken from the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (push && in_oob && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  // The buffer is empty whenever SCAN is active, so the mux only picks which
  // register bank drives the pins.
  assign in_ready  = buf_rdy;
  assign out_valid = (state_q == SCAN) ? scan_vld_q   : buf_vld;
  assign out_lines = (state_q == SCAN) ? scan_lines_q : buf_dat[N_OUT-1:0];
  assign out_err   = (state_q == SCAN) ? 1'b0         : buf_dat[N_OUT];
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_bcd_decoder_scan.sv
// Directed bench for the line decoder: default 10-line active-low part plus an 8-line active-high part.
// Latency: checks beat timing cycle by cycle, sampling 1 time unit after each rising edge.
// Backpressure: exercises out_ready stalls, buffer full and mode drain.
module tb_bcd_decoder_scan;

  logic       clk;
  logic       rst_n;
  logic       mode;
  logic [7:0] dwell;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_sel;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_lines;
  logic       out_err;
  logic [7:0] err_cnt;

  logic       mode8;
  logic [7:0] dwell8;
  logic       in_valid8;
  logic       in_ready8;
  logic [2:0] in_sel8;
  logic       out_valid8;
  logic       out_ready8;
  logic [7:0] out_lines8;
  logic       out_err8;
  logic [7:0] err_cnt8;

  int checks;
  int errors;

  bcd_decoder_scan u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .dwell     (dwell),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lines (out_lines),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  bcd_decoder_scan #(
    .SEL_W      (3),
    .N_OUT      (8),
    .ACTIVE_LOW (1'b0),
    .DWELL_W    (8)
  ) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode8),
    .dwell     (dwell8),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_sel    (in_sel8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_lines (out_lines8),
    .out_err   (out_err8),
    .err_cnt   (err_cnt8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk(tag, 32'(in_ready), 1);
  endtask

  // Expected active-low lines for the default 10-line part.
  function automatic logic [9:0] exp_al(input int s);
    logic [9:0] v;
    v = '1;
    if (s < 10) v[s] = 1'b0;
    return v;
  endfunction

  initial begin
    int acc;
    bit seen200;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    mode      = 1'b0;
    dwell     = 8'd0;
    in_valid  = 1'b0;
    in_sel    = 4'd0;
    out_ready = 1'b0;
    mode8     = 1'b0;
    dwell8    = 8'd0;
    in_valid8 = 1'b0;
    in_sel8   = 3'd0;
    out_ready8 = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_lines", 32'(out_lines), 32'h3FF);
    chk("rst_err", 32'(out_err), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_lines8", 32'(out_lines8), 32'h00);
    rst_n = 1'b1;

    // 1: stream 0..15 back to back
    out_ready = 1'b1;
    wait_rdy("t1_rdy");
    for (int s = 0; s < 16; s++) begin
      in_valid = 1'b1;
      in_sel   = 4'(s);
      step();
      chk($sformatf("t1_vld_%0d", s), 32'(out_valid), 1);
      chk($sformatf("t1_lines_%0d", s), 32'(out_lines), 32'(exp_al(s)));
      chk($sformatf("t1_err_%0d", s), 32'(out_err), (s >= 10) ? 1 : 0);
      if (s == 3) chk("t1_sel3", 32'(out_lines), 32'b11_1111_0111);
      if (s == 12) chk("t1_sel12", 32'(out_lines), 32'h3FF);
    end
    in_valid = 1'b0;
    step();
    chk("t1_idle_vld", 32'(out_valid), 0);
    chk("t1_err_cnt", 32'(err_cnt), 6);

    // 6a: active-high 8-line part
    in_valid8 = 1'b1;
    in_sel8   = 3'd6;
    step();
    chk("t6_vld8", 32'(out_valid8), 1);
    chk("t6_sel6", 32'(out_lines8), 32'b0100_0000);
    chk("t6_err6", 32'(out_err8), 0);
    in_sel8 = 3'd7;
    step();
    chk("t6_sel7", 32'(out_lines8), 32'h80);
    chk("t6_err7", 32'(out_err8), 0);
    in_valid8 = 1'b0;
    step();
    chk("t6_idle8", 32'(out_lines8), 32'h00);
    chk("t6_errcnt8", 32'(err_cnt8), 0);

    // 2: backpressure, 3 beats into a 2-entry buffer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 4'd1;
    step();
    chk("t2_rdy_after1", 32'(in_ready), 1);
    in_sel = 4'd2;
    step();
    chk("t2_rdy_full", 32'(in_ready), 0);
    in_sel = 4'd3;
    step();
    chk("t2_hold_lines", 32'(out_lines), 32'h3FD);
    chk("t2_hold_vld", 32'(out_valid), 1);
    out_ready = 1'b1;
    step();
    chk("t2_out2", 32'(out_lines), 32'h3FB);
    chk("t2_rdy_after_pop", 32'(in_ready), 1);
    step();
    chk("t2_out3", 32'(out_lines), 32'h3F7);
    chk("t2_vld3", 32'(out_valid), 1);
    in_valid = 1'b0;
    step();
    chk("t2_empty_vld", 32'(out_valid), 0);
    chk("t2_empty_lines", 32'(out_lines), 32'h3FF);

    // 4: switch to SCAN with two beats buffered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 4'd4;
    step();
    in_sel = 4'd5;
    step();
    chk("t4_full", 32'(in_ready), 0);
    in_valid = 1'b0;
    mode     = 1'b1;
    dwell    = 8'd0;
    step();
    chk("t4_drain_rdy", 32'(in_ready), 0);
    chk("t4_drain_head", 32'(out_lines), 32'h3EF);
    out_ready = 1'b1;
    step();
    chk("t4_drain_second", 32'(out_lines), 32'h3DF);
    chk("t4_drain_vld", 32'(out_valid), 1);
    chk("t4_drain_rdy2", 32'(in_ready), 0);
    step();
    chk("t4_drained_vld", 32'(out_valid), 0);
    chk("t4_drained_lines", 32'(out_lines), 32'h3FF);
    step();
    chk("t4_scan_idx0", 32'(out_lines), 32'h3FE);
    chk("t4_scan_vld", 32'(out_valid), 1);
    chk("t4_scan_err", 32'(out_err), 0);

    // Leave SCAN through IDLE, then re-enter with dwell 2
    mode  = 1'b0;
    dwell = 8'd2;
    step();
    chk("t3_idle_vld", 32'(out_valid), 0);
    chk("t3_idle_lines", 32'(out_lines), 32'h3FF);
    mode = 1'b1;

    // 3: scan, dwell 2, each line 3 cycles with strobe on the third
    for (int c = 0; c < 48; c++) begin
      step();
      chk($sformatf("t3_lines_c%0d", c), 32'(out_lines), 32'(exp_al((c / 3) % 10)));
      chk($sformatf("t3_vld_c%0d", c), 32'(out_valid), (c % 3 == 2) ? 1 : 0);
      chk($sformatf("t3_rdy_c%0d", c), 32'(in_ready), 0);
    end

    // 5: asynchronous reset mid-scan at line 5 with a strobe up
    chk("t5_pre_lines", 32'(out_lines), 32'h3DF);
    chk("t5_pre_errcnt", 32'(err_cnt), 6);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_vld", 32'(out_valid), 0);
    chk("t5_rst_lines", 32'(out_lines), 32'h3FF);
    chk("t5_rst_errcnt", 32'(err_cnt), 0);
    mode = 1'b0;
    step();
    rst_n = 1'b1;

    // 6b: 300 out-of-range beats saturate the counter
    out_ready = 1'b1;
    wait_rdy("t6_rdy");
    in_valid = 1'b1;
    in_sel   = 4'd15;
    acc      = 0;
    seen200  = 1'b0;
    for (int i = 0; i < 400 && acc < 300; i++) begin
      if (in_ready) acc++;
      step();
      if (acc == 200 && !seen200) begin
        seen200 = 1'b1;
        chk("t6_errcnt200", 32'(err_cnt), 200);
      end
    end
    in_valid = 1'b0;
    chk("t6_accepted", 32'(acc), 300);
    chk("t6_errcnt_sat", 32'(err_cnt), 255);
    chk("t6_err_flag", 32'(out_err), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
